// File: rtl/maq_bcd_mod_pkg.sv
// Shared types and helpers for the two-digit BCD modulo counter.
package maq_pkg;

  typedef enum logic {ST_RUN, ST_SET} maq_state_t;

  typedef logic [3:0] bcd_t;

  // Binary view of a count; 8 bits covers any 4-bit tens/units pair (max 165).
  typedef logic [7:0] bin_t;

  localparam bin_t H12_MIN = 8'd1;
  localparam bin_t H12_MAX = 8'd12;

  function automatic bin_t bcd_to_bin(input bcd_t lsd, input logic [3:0] msd);
    return bin_t'(msd) * 8'd10 + bin_t'(lsd);
  endfunction

  function automatic logic bcd_in_range(input bcd_t lsd, input logic [3:0] msd,
                                        input bin_t min_v, input bin_t max_v);
    bin_t v;
    v = bcd_to_bin(lsd, msd);
    return (lsd <= 4'd9) && (v >= min_v) && (v <= max_v);
  endfunction

endpackage

// File: rtl/maq_bcd_mod_step.sv
// One-step increment/decrement of a two-digit BCD count with modulo wrap.
module maq_bcd_step
  import maq_pkg::*;
#(
  parameter int MSD_W     = 2,
  parameter bit HOUR12_EN = 1'b0
) (
  input  bcd_t             cur_lsd,
  input  logic [MSD_W-1:0] cur_msd,
  input  logic             dir_up,
  input  bin_t             min_val,
  input  bin_t             max_val,
  output bcd_t             nxt_lsd,
  output logic [MSD_W-1:0] nxt_msd,
  output logic             wrap,
  output logic             pm_toggle
);

  bin_t cur;
  bin_t nxt;

  // Step in binary and convert back to digits; wrap at the range limits.
  always_comb begin
    cur       = bcd_to_bin(cur_lsd, 4'(cur_msd));
    nxt       = cur;
    wrap      = 1'b0;
    pm_toggle = 1'b0;
    if (dir_up) begin
      if (cur == max_val) begin
        nxt  = min_val;
        wrap = 1'b1;
      end else begin
        nxt = cur + 8'd1;
      end
    end else begin
      if (cur == min_val) begin
        nxt  = max_val;
        wrap = 1'b1;
      end else begin
        nxt = cur - 8'd1;
      end
    end
    if (HOUR12_EN) begin
      pm_toggle = dir_up ? (cur == 8'd11) : (cur == 8'd12);
    end
    nxt_lsd = 4'(nxt % 8'd10);
    nxt_msd = MSD_W'(nxt / 8'd10);
  end

endmodule

// File: rtl/maq_bcd_mod.sv
// Two-digit BCD modulo counter with preset, manual set mode, carry and 12 h PM.
module maq_bcd_mod
  import maq_pkg::*;
#(
  parameter int MSD_W     = 2,
  parameter int MAX_VAL   = 23,
  parameter int MIN_VAL   = 0,
  parameter bit HOUR12_EN = 1'b0
) (
  input  logic             maqb_clock,
  input  logic             maqb_reset,
  input  logic             maqb_enable,
  input  logic             maqb_tick,
  input  logic             maqb_set_mode,
  input  logic             maqb_up,
  input  logic             maqb_down,
  input  logic             maqb_load,
  input  logic [3:0]       maqb_load_lsd,
  input  logic [MSD_W-1:0] maqb_load_msd,
  output logic [3:0]       maqb_Lsd,
  output logic [MSD_W-1:0] maqb_Msd,
  output logic             maqb_pm,
  output logic             maqb_carry,
  output logic             maqb_setting,
  output logic             maqb_load_err
);

  localparam bin_t EFF_MIN = HOUR12_EN ? H12_MIN : bin_t'(MIN_VAL);
  localparam bin_t EFF_MAX = HOUR12_EN ? H12_MAX : bin_t'(MAX_VAL);
  localparam bin_t RST_VAL = HOUR12_EN ? H12_MAX : EFF_MIN;
  localparam bcd_t             RST_LSD = bcd_t'(RST_VAL % 8'd10);
  localparam logic [MSD_W-1:0] RST_MSD = MSD_W'(RST_VAL / 8'd10);

  maq_state_t       state_q, state_d;
  bcd_t             lsd_q, lsd_d;
  logic [MSD_W-1:0] msd_q, msd_d;
  logic             pm_q, pm_d;
  logic             carry_q, carry_d;
  logic             err_q, err_d;

  logic             in_set;
  logic             step_req;
  logic             step_up;
  logic             load_ok;
  bcd_t             step_lsd;
  logic [MSD_W-1:0] step_msd;
  logic             step_wrap;
  logic             step_pm_toggle;

  // RUN ticks and SET steps share one stepper; only the direction source differs.
  maq_bcd_step #(
    .MSD_W     (MSD_W),
    .HOUR12_EN (HOUR12_EN)
  ) u_step (
    .cur_lsd   (lsd_q),
    .cur_msd   (msd_q),
    .dir_up    (step_up),
    .min_val   (EFF_MIN),
    .max_val   (EFF_MAX),
    .nxt_lsd   (step_lsd),
    .nxt_msd   (step_msd),
    .wrap      (step_wrap),
    .pm_toggle (step_pm_toggle)
  );

  // Next state: load beats stepping; SET steps and RUN ticks are mutually exclusive.
  always_comb begin
    state_d  = maqb_set_mode ? ST_SET : ST_RUN;
    in_set   = (state_q == ST_SET);
    step_up  = in_set ? maqb_up : 1'b1;
    step_req = in_set ? (maqb_up ^ maqb_down) : (maqb_tick & maqb_enable);
    load_ok  = bcd_in_range(maqb_load_lsd, 4'(maqb_load_msd), EFF_MIN, EFF_MAX);
    lsd_d    = lsd_q;
    msd_d    = msd_q;
    pm_d     = pm_q;
    carry_d  = 1'b0;
    err_d    = 1'b0;
    if (maqb_load) begin
      if (load_ok) begin
        lsd_d = maqb_load_lsd;
        msd_d = maqb_load_msd;
      end else begin
        err_d = 1'b1;
      end
    end else if (step_req) begin
      lsd_d   = step_lsd;
      msd_d   = step_msd;
      pm_d    = pm_q ^ step_pm_toggle;
      carry_d = step_wrap & ~in_set;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge maqb_clock) begin
    if (maqb_reset) begin
      state_q <= ST_RUN;
      lsd_q   <= RST_LSD;
      msd_q   <= RST_MSD;
      pm_q    <= 1'b0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lsd_q   <= lsd_d;
      msd_q   <= msd_d;
      pm_q    <= pm_d;
      carry_q <= carry_d;
      err_q   <= err_d;
    end
  end

  assign maqb_Lsd      = lsd_q;
  assign maqb_Msd      = msd_q;
  assign maqb_pm       = pm_q;
  assign maqb_carry    = carry_q;
  assign maqb_setting  = (state_q == ST_SET);
  assign maqb_load_err = err_q;

endmodule

// File: tb/tb_maq_bcd_mod.sv
// Bench for maq_bcd_mod: 00-23, 00-59 and 12 h instances driven by common stimulus.
module tb_maq_bcd_mod;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, tick, setm, up, dn, ld;
  logic [3:0] ld_lsd;
  logic [2:0] ld_msd;

  logic [3:0] a_lsd, b_lsd, c_lsd;
  logic [1:0] a_msd, c_msd;
  logic [2:0] b_msd;
  logic a_pm, a_carry, a_set, a_err;
  logic b_pm, b_carry, b_set, b_err;
  logic c_pm, c_carry, c_set, c_err;

  maq_bcd_mod #(.MSD_W(2), .MAX_VAL(23), .MIN_VAL(0), .HOUR12_EN(1'b0)) dut_a (
    .maqb_clock(clk), .maqb_reset(rst), .maqb_enable(en), .maqb_tick(tick),
    .maqb_set_mode(setm), .maqb_up(up), .maqb_down(dn), .maqb_load(ld),
    .maqb_load_lsd(ld_lsd), .maqb_load_msd(ld_msd[1:0]),
    .maqb_Lsd(a_lsd), .maqb_Msd(a_msd), .maqb_pm(a_pm), .maqb_carry(a_carry),
    .maqb_setting(a_set), .maqb_load_err(a_err));

  maq_bcd_mod #(.MSD_W(3), .MAX_VAL(59), .MIN_VAL(0), .HOUR12_EN(1'b0)) dut_b (
    .maqb_clock(clk), .maqb_reset(rst), .maqb_enable(en), .maqb_tick(tick),
    .maqb_set_mode(setm), .maqb_up(up), .maqb_down(dn), .maqb_load(ld),
    .maqb_load_lsd(ld_lsd), .maqb_load_msd(ld_msd),
    .maqb_Lsd(b_lsd), .maqb_Msd(b_msd), .maqb_pm(b_pm), .maqb_carry(b_carry),
    .maqb_setting(b_set), .maqb_load_err(b_err));

  maq_bcd_mod #(.MSD_W(2), .MAX_VAL(23), .MIN_VAL(0), .HOUR12_EN(1'b1)) dut_c (
    .maqb_clock(clk), .maqb_reset(rst), .maqb_enable(en), .maqb_tick(tick),
    .maqb_set_mode(setm), .maqb_up(up), .maqb_down(dn), .maqb_load(ld),
    .maqb_load_lsd(ld_lsd), .maqb_load_msd(ld_msd[1:0]),
    .maqb_Lsd(c_lsd), .maqb_Msd(c_msd), .maqb_pm(c_pm), .maqb_carry(c_carry),
    .maqb_setting(c_set), .maqb_load_err(c_err));

  // Reference model: count kept as a plain integer per instance.
  int mmin[3] = '{0, 0, 1};
  int mmax[3] = '{23, 59, 12};
  int mmask[3] = '{3, 7, 3};
  bit h12[3] = '{1'b0, 1'b0, 1'b1};
  int mv[3];
  bit mpm[3], mcar[3], merr[3], mset[3];

  int n_cmp = 0;
  int n_bad = 0;
  bit chk = 1'b0;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model update on each active edge from the inputs held since the last falling edge.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        mv[i] = h12[i] ? 12 : mmin[i];
        mpm[i] = 0; mcar[i] = 0; merr[i] = 0; mset[i] = 0;
      end else begin
        automatic bit was_set = mset[i];
        automatic int lv = (int'(ld_msd) & mmask[i]) * 10 + int'(ld_lsd);
        mcar[i] = 0;
        merr[i] = 0;
        if (ld) begin
          if (ld_lsd <= 9 && lv >= mmin[i] && lv <= mmax[i]) mv[i] = lv;
          else merr[i] = 1;
        end else if ((was_set && up && !dn) || (!was_set && tick && en)) begin
          if (h12[i] && mv[i] == 11) mpm[i] = !mpm[i];
          if (mv[i] == mmax[i]) begin
            mv[i] = mmin[i];
            mcar[i] = !was_set;
          end else mv[i] = mv[i] + 1;
        end else if (was_set && dn && !up) begin
          if (h12[i] && mv[i] == 12) mpm[i] = !mpm[i];
          mv[i] = (mv[i] == mmin[i]) ? mmax[i] : mv[i] - 1;
        end
        mset[i] = setm;
      end
    end
  end

  // Compare all outputs of all instances against the model every cycle.
  always @(negedge clk) begin
    if (chk) begin
      for (int i = 0; i < 3; i++) begin
        int al, am, ap, ac, as_, ae;
        case (i)
          0: begin al = a_lsd; am = a_msd; ap = a_pm; ac = a_carry; as_ = a_set; ae = a_err; end
          1: begin al = b_lsd; am = b_msd; ap = b_pm; ac = b_carry; as_ = b_set; ae = b_err; end
          default: begin al = c_lsd; am = c_msd; ap = c_pm; ac = c_carry; as_ = c_set; ae = c_err; end
        endcase
        check($sformatf("lsd[%0d]", i), al, mv[i] % 10);
        check($sformatf("msd[%0d]", i), am, mv[i] / 10);
        check($sformatf("pm[%0d]", i), ap, int'(mpm[i]));
        check($sformatf("carry[%0d]", i), ac, int'(mcar[i]));
        check($sformatf("setting[%0d]", i), as_, int'(mset[i]));
        check($sformatf("load_err[%0d]", i), ae, int'(merr[i]));
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic idle();
    tick = 0; up = 0; dn = 0; ld = 0; rst = 0;
  endtask

  int carries;

  initial begin
    rst = 1; en = 0; tick = 0; setm = 0; up = 0; dn = 0; ld = 0;
    ld_lsd = '0; ld_msd = '0;
    repeat (2) cyc();
    chk = 1;
    check("pin_rst_a", a_msd * 10 + a_lsd, 0);
    check("pin_rst_b", b_msd * 10 + b_lsd, 0);
    check("pin_rst_c", c_msd * 10 + c_lsd, 12);
    check("pin_rst_c_pm", c_pm, 0);
    idle();

    // 24 ticks: A walks 00..23 then 00 with exactly one carry.
    en = 1; tick = 1; carries = 0;
    for (int k = 1; k <= 24; k++) begin
      cyc();
      carries += a_carry;
      if (k == 11) begin
        check("pin_c11", c_msd * 10 + c_lsd, 11);
        check("pin_c11_pm", c_pm, 0);
      end
      if (k == 12) begin
        check("pin_c12", c_msd * 10 + c_lsd, 12);
        check("pin_c12_pm", c_pm, 1);
      end
      if (k == 23) check("pin_a23", a_msd * 10 + a_lsd, 23);
    end
    tick = 0;
    cyc();
    carries += a_carry;
    check("pin_a_wrap", a_msd * 10 + a_lsd, 0);
    check("pin_a_carries", carries, 1);

    // Preset to 59 on B, wrap with carry, then a rejected load.
    ld = 1; ld_lsd = 4'd9; ld_msd = 3'd5; cyc(); ld = 0;
    check("pin_b59", b_msd * 10 + b_lsd, 59);
    tick = 1; cyc(); tick = 0;
    check("pin_b_wrap", b_msd * 10 + b_lsd, 0);
    check("pin_b_carry", b_carry, 1);
    cyc();
    check("pin_b_carry_drop", b_carry, 0);
    ld = 1; ld_lsd = 4'd9; ld_msd = 3'd5; cyc();
    ld_lsd = 4'd0; ld_msd = 3'd6; cyc(); ld = 0;
    check("pin_b_badload", b_msd * 10 + b_lsd, 59);
    check("pin_b_err", b_err, 1);
    cyc();
    check("pin_b_err_drop", b_err, 0);

    // Set mode at 00: decrement wraps, both buttons and ticks are ignored.
    rst = 1; cyc(); rst = 0;
    setm = 1; cyc();
    check("pin_a_setting", a_set, 1);
    dn = 1; cyc(); dn = 0;
    check("pin_a_dn", a_msd * 10 + a_lsd, 23);
    check("pin_c_dn", c_msd * 10 + c_lsd, 11);
    check("pin_c_dn_pm", c_pm, 1);
    check("pin_c_dn_carry", c_carry, 0);
    up = 1; dn = 1; cyc(); up = 0; dn = 0;
    check("pin_a_updn", a_msd * 10 + a_lsd, 23);
    tick = 1; cyc(); tick = 0;
    check("pin_a_tick_in_set", a_msd * 10 + a_lsd, 23);
    setm = 0; cyc();
    check("pin_a_setting_drop", a_set, 0);
    tick = 1; cyc(); tick = 0;
    check("pin_a_run_again", a_msd * 10 + a_lsd, 0);

    // Load and tick together, then ticks with enable low.
    ld = 1; ld_lsd = 4'd2; ld_msd = 3'd1; tick = 1; cyc(); ld = 0;
    check("pin_a_load_wins", a_msd * 10 + a_lsd, 12);
    en = 0; repeat (3) cyc(); tick = 0; en = 1;
    check("pin_a_frozen", a_msd * 10 + a_lsd, 12);

    // Reset in the middle of set mode with an up pulse.
    setm = 1; cyc();
    up = 1; rst = 1; cyc(); idle(); setm = 0;
    check("pin_a_rst_set", a_msd * 10 + a_lsd, 0);
    check("pin_a_rst_setting", a_set, 0);
    check("pin_c_rst_pm", c_pm, 0);

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      rst  = ($urandom_range(0, 99) == 0);
      en   = ($urandom_range(0, 4) != 0);
      tick = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) setm = !setm;
      up   = ($urandom_range(0, 3) == 0);
      dn   = ($urandom_range(0, 3) == 0);
      ld   = ($urandom_range(0, 14) == 0);
      ld_lsd = 4'($urandom_range(0, 10));
      ld_msd = 3'($urandom_range(0, 6));
      cyc();
    end
    idle();
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
